ped_crossing_ctrl: RTL

//  Pedestrian end of the traffic-light handshake. Debounces the crossing push-button and drives IN
//  (the crossing request) into the traffic FSM. Waits for that FSM to grant the crossing
//  (Pasar_Persona with Rojo), then sequences the pedestrian lamps: WALK, flashing DON'T-WALK, CLEAR.

---
 rtl/ped_pkg.sv | 19 +
 rtl/btn_debounce.sv | 57 +++++
 rtl/ped_crossing_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ped_pkg.sv
// Shared types and default timing constants for the pedestrian crossing controller.
package ped_pkg;

    // Pedestrian sequencer states; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        WALK    = 3'd2,
        FLASH   = 3'd3,
        CLEAR   = 3'd4
    } ped_state_t;

    localparam int DEF_DEB_CYCLES   = 4;
    localparam int DEF_WALK_CYCLES  = 10;
    localparam int DEF_FLASH_CYCLES = 6;
    localparam int DEF_FLASH_HALF   = 2;
    localparam int DEF_CNT_W        = 4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchronizer, run-length debounce, and a
// single-cycle pulse on each accepted press.
module btn_debounce
    import ped_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;

    // Count consecutive synchronized-high samples; the counter saturates so a
    // held button keeps the debounced level high without wrapping.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = 1'b0;
        if (!sync2_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != DEB_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            level_d = (cnt_q >= DEB_LAST);
        end
    end

    // Synchronizer, debounce counter and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian side of the traffic-light handshake: raises the crossing request,
// waits for a grant on vehicle red, then runs WALK, flashing DON'T-WALK, CLEAR.
// All lamp outputs are decoded from registered state only.
module ped_crossing_ctrl
    import ped_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int WALK_CYCLES  = DEF_WALK_CYCLES,
    parameter int FLASH_CYCLES = DEF_FLASH_CYCLES,
    parameter int FLASH_HALF   = DEF_FLASH_HALF,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boton,
    input  logic             Rojo,
    input  logic             Pasar_Persona,
    output logic             IN,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic [2:0]       Estado
);

    localparam int BW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(FLASH_HALF - 1);

    ped_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             pending_q, pending_d;
    logic             press;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (boton),
        .press_o (press)
    );

    // Next-state, phase countdown, pending-press latch and blink divider.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                // A press arriving in the same cycle as entry is absorbed.
                if (press || pending_q) begin
                    state_d   = REQUEST;
                    pending_d = 1'b0;
                end
            end
            REQUEST: begin
                // A grant only counts once vehicles actually see red.
                if (Pasar_Persona && Rojo) begin
                    state_d = WALK;
                    cnt_d   = WALK_LOAD;
                end
            end
            WALK: begin
                if (press) begin
                    pending_d = 1'b1;
                end
                // Abort and expiry collapse into the same single move to FLASH.
                if (!Pasar_Persona || (cnt_q == '0)) begin
                    state_d = FLASH;
                    cnt_d   = FLASH_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FLASH: begin
                if (press) begin
                    pending_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CLEAR: begin
                if (press) begin
                    pending_d = 1'b1;
                end
                cnt_d = '0;
                if (!Pasar_Persona) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Blink restarts lit on every FLASH entry and only runs while staying in FLASH.
        blink_d = 1'b1;
        bcnt_d  = '0;
        if ((state_q == FLASH) && (state_d == FLASH)) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
                blink_d = blink_q;
            end
        end
    end

    // State, countdown, blink and pending registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            blink_q   <= 1'b1;
            bcnt_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            bcnt_q    <= bcnt_d;
            pending_q <= pending_d;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        IN        = 1'b0;
        walk      = 1'b0;
        dont_walk = 1'b1;
        countdown = '0;
        case (state_q)
            REQUEST: IN = 1'b1;
            WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
                countdown = cnt_q;
            end
            FLASH: begin
                dont_walk = blink_q;
                countdown = cnt_q;
            end
            default: ;
        endcase
    end

    assign Estado = state_q;

endmodule
